// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants: next-PC source encodings, bubble instruction and reset PC.
package fetch_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_plus4  = 2'b00,
        PC_target = 2'b01,
        PC_alu    = 2'b10,
        PC_rsvd   = 2'b11
    } pcsrc_e;

    function automatic logic isRedirect(input pcsrc_e src);
        return (src == PC_target) || (src == PC_alu);
    endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg_fd.sv
// Generic pipeline register with hold enable and synchronous clear; clear beats hold.
module pipe_reg_fd #(
    parameter int W = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register stage: async reset and sync clear both load the bubble value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= CLR_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection and the IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            MisalignF
);

    localparam int FD_W = 1 + 32 + 2 * XLEN;
    localparam logic [FD_W-1:0] FD_CLR = {1'b0, NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};

    logic [XLEN-1:0] pcPlus4F_s;
    logic [XLEN-1:0] pcNext_s;
    logic            redirect_s;
    logic [FD_W-1:0] fdQ_s;

    // Next-PC mux; the reserved encoding falls back to sequential fetch.
    always_comb begin
        pcPlus4F_s = PCF + XLEN'(4);
        redirect_s = isRedirect(pcsrc_e'(PCSrcE));
        pcNext_s   = pcPlus4F_s;
        case (pcsrc_e'(PCSrcE))
            PC_target: pcNext_s = PCTargetE;
            PC_alu:    pcNext_s = {ALUResultE[XLEN-1:1], 1'b0};
            default:   pcNext_s = pcPlus4F_s;
        endcase
    end

    // PC register: a redirect overrides StallF so a flushed stream never stalls the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF       <= RESET_PC;
            MisalignF <= 1'b0;
        end else if (redirect_s) begin
            PCF       <= pcNext_s;
            MisalignF <= MisalignF | pcNext_s[1];
        end else if (!StallF) begin
            PCF       <= pcPlus4F_s;
            MisalignF <= MisalignF;
        end else begin
            PCF       <= PCF;
            MisalignF <= MisalignF;
        end
    end

    pipe_reg_fd #(
        .W       (FD_W),
        .CLR_VAL (FD_CLR)
    ) u_regFD (
        .clk (clk),
        .rst (rst),
        .en  (~StallD),
        .clr (FlushD),
        .d   ({1'b1, InstrF, PCF, pcPlus4F_s}),
        .q   (fdQ_s)
    );

    assign {ValidD, InstrD, PCD, PCPlus4D} = fdQ_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural model compared every cycle plus literal pins.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE, InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignF;

    int checks = 0;
    int failures = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .MisalignF  (MisalignF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        return addr | 32'hA000_0000;
    endfunction

    // Combinational instruction memory
    always_comb InstrF = imem(PCF);

    // Model state
    logic [31:0] mPc, mInstr, mPcD, mP4D;
    logic        mValid, mMis;

    always @(posedge clk or posedge rst) begin
        logic [31:0] tgt;
        logic        redir;
        if (rst) begin
            mPc <= 32'h0; mInstr <= 32'h13; mPcD <= 32'h0; mP4D <= 32'h0;
            mValid <= 1'b0; mMis <= 1'b0;
        end else begin
            redir = (PCSrcE == 2'd1) || (PCSrcE == 2'd2);
            tgt = (PCSrcE == 2'd1) ? PCTargetE : (ALUResultE & 32'hFFFF_FFFE);
            if (FlushD) begin
                mInstr <= 32'h13; mPcD <= 32'h0; mP4D <= 32'h0; mValid <= 1'b0;
            end else if (!StallD) begin
                mInstr <= imem(mPc); mPcD <= mPc; mP4D <= mPc + 32'd4; mValid <= 1'b1;
            end
            if (redir) begin
                mPc <= tgt;
                if (tgt[1]) mMis <= 1'b1;
            end else if (!StallF) begin
                mPc <= mPc + 32'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_PCF", PCF, mPc);
        chk("m_InstrD", InstrD, mInstr);
        chk("m_PCD", PCD, mPcD);
        chk("m_PCPlus4D", PCPlus4D, mP4D);
        chk("m_ValidD", {31'd0, ValidD}, {31'd0, mValid});
        chk("m_MisalignF", {31'd0, MisalignF}, {31'd0, mMis});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 2'b00; PCTargetE = 32'h0; ALUResultE = 32'h0;
        cyc(2);
        rst = 1'b0;
        #1;
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_InstrD", InstrD, 32'h13);
        cyc(1);
        chk("seq1_PCF", PCF, 32'h4);
        cyc(1);
        chk("seq2_PCF", PCF, 32'h8);
        chk("seq2_InstrD", InstrD, 32'hA000_0004);
        chk("seq2_PCD", PCD, 32'h4);
        chk("seq2_PCPlus4D", PCPlus4D, 32'h8);
        cyc(1);
        // Load-use stall at PCF=12
        StallF = 1'b1; StallD = 1'b1;
        cyc(2);
        chk("stall_PCF", PCF, 32'hC);
        chk("stall_InstrD", InstrD, 32'hA000_0008);
        chk("stall_PCD", PCD, 32'h8);
        StallF = 1'b0; StallD = 1'b0;
        cyc(1);
        chk("unstall_PCF", PCF, 32'h10);
        chk("unstall_InstrD", InstrD, 32'hA000_000C);
        // Taken branch with flush
        PCSrcE = 2'b01; PCTargetE = 32'h40; FlushD = 1'b1;
        cyc(1);
        chk("br_PCF", PCF, 32'h40);
        chk("br_ValidD", {31'd0, ValidD}, 32'd0);
        chk("br_InstrD", InstrD, 32'h13);
        PCSrcE = 2'b00; FlushD = 1'b0;
        cyc(1);
        chk("br2_InstrD", InstrD, 32'hA000_0040);
        chk("br2_ValidD", {31'd0, ValidD}, 32'd1);
        // Reserved select behaves as sequential
        PCSrcE = 2'b11; PCTargetE = 32'h2; ALUResultE = 32'h6;
        cyc(1);
        chk("rsvd_PCF", PCF, 32'h48);
        chk("rsvd_Mis", {31'd0, MisalignF}, 32'd0);
        // StallF without StallD duplicates the fetched instruction
        PCSrcE = 2'b00; StallF = 1'b1;
        cyc(1);
        chk("dup_PCF", PCF, 32'h48);
        chk("dup_InstrD", InstrD, 32'hA000_0048);
        StallF = 1'b0;
        // JALR with odd, bit-1 target
        PCSrcE = 2'b10; ALUResultE = 32'h107; FlushD = 1'b1;
        cyc(1);
        chk("jalr_PCF", PCF, 32'h106);
        chk("jalr_Mis", {31'd0, MisalignF}, 32'd1);
        PCSrcE = 2'b00; FlushD = 1'b0;
        cyc(3);
        chk("mis_sticky", {31'd0, MisalignF}, 32'd1);
        // Redirect and flush beat simultaneous stalls
        StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
        PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFF8;
        cyc(1);
        chk("sim_PCF", PCF, 32'hFFFF_FFF8);
        chk("sim_InstrD", InstrD, 32'h13);
        chk("sim_PCD", PCD, 32'h0);
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
        cyc(1);
        chk("wrap1_PCF", PCF, 32'hFFFF_FFFC);
        cyc(1);
        chk("wrap2_PCF", PCF, 32'h0);
        chk("wrap2_PCD", PCD, 32'hFFFF_FFFC);
        chk("wrap2_PCPlus4D", PCPlus4D, 32'h0);
        cyc(2);
        // Mid-cycle asynchronous reset
        rst = 1'b1;
        #1;
        chk("arst_PCF", PCF, 32'h0);
        chk("arst_InstrD", InstrD, 32'h13);
        chk("arst_ValidD", {31'd0, ValidD}, 32'd0);
        chk("arst_Mis", {31'd0, MisalignF}, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("rel_PCF", PCF, 32'h4);
        cyc(1);
        chk("rel2_PCF", PCF, 32'h8);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.
- Holds the PC and selects the next PC from sequential, branch/JAL target or JALR target.
- Latches the fetched instruction into the decode stage, honouring the hazard unit's StallF/StallD/FlushD.
- Feeds decode (InstrD, PCD, PCPlus4D) and drives the instruction-memory address.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) injected into D on flush/reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- StallF  input  1  hold PC register.
- StallD  input  1  hold IF/ID register.
- FlushD  input  1  replace IF/ID contents with bubble.
- PCSrcE  input  2  next-PC select: 00 PC+4, 01 PCTargetE, 10 ALUResultE, 11 reserved (treated as 00).
- PCTargetE  input  XLEN  branch/JAL target from EX.
- ALUResultE  input  XLEN  JALR target from EX (bit 0 cleared internally).
- InstrF  input  32  instruction word from combinational instruction memory at PCF.
- PCF  output  XLEN  current fetch address to instruction memory.
- InstrD  output  32  instruction in decode.
- PCD  output  XLEN  PC of InstrD.
- PCPlus4D  output  XLEN  PCD+4.
- ValidD  output  1  1 = InstrD is a real fetched instruction, 0 = bubble.
- MisalignF  output  1  sticky flag: a redirect target had bit 1 set.

Behaviour:
- Reset (async, immediate):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignF=0.
  - Reset released mid-stream: first fetch is from RESET_PC on the next rising edge; no partial state survives.
- PC path:
  - PCPlus4F = PCF+4, modulo 2^XLEN; 32'hFFFFFFFC wraps to 0 silently.
  - JALR target = {ALUResultE[XLEN-1:1],1'b0}.
  - Redirect = PCSrcE is 01 or 10.
- PC register update at each rising edge:
  - Redirect: PCF <= selected target, regardless of StallF. Redirect has priority.
  - Else StallF=1: PCF holds.
  - Else: PCF <= PCPlus4F.
- IF/ID register update at each rising edge, in priority order:
  1. FlushD=1: InstrD <= NOP_INSTR, ValidD <= 0, PCD/PCPlus4D <= 0. FlushD beats StallD.
  2. Else StallD=1: all D outputs hold.
  3. Else: InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- Latency:
  - Instruction at PCF appears on InstrD one cycle later.
  - A redirect asserted in cycle N makes PCF=target in N+1 and InstrD=target's instruction in N+2.
- MisalignF:
  - Set when a redirect is taken and the selected target[1] is 1.
  - Cleared only by rst.
  - PC is still loaded with the target unchanged.
- Stall without flush holds PCF and D contents indefinitely; multi-cycle stalls are legal.
- StallF=1 with StallD=0 is tolerated: D re-latches the same InstrF, so a duplicate instruction is issued. The hazard unit never produces this.
- PCSrcE=11: behaves as 00; no flag.
- All outputs are registered; no combinational path from inputs to outputs except PCF's feed to instruction memory.

Decomposition:
- Shared constants package (same file as the hazard unit's):
  - PC source encodings PC_plus4, PC_target, PC_alu.
  - NOP_INSTR.
  - RESET_PC default.
- One natural sub-module, pipe_reg_fd: the IF/ID register with enable (~StallD) and synchronous clear (FlushD). It is reusable for the later D/E, E/M and M/W registers.
- PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset: assert rst mid-cycle -> PCF=0, InstrD=32'h00000013, ValidD=0 immediately; release -> PCF steps 0,4,8 on successive edges.
- Sequential fetch: imem returns PC|32'hA0000000 -> InstrD one cycle behind PCF, e.g. PCF=8 when InstrD=32'hA0000004, PCD=4, PCPlus4D=8.
- Load-use stall: StallF=StallD=1 for 2 cycles at PCF=12 -> PCF stays 12, InstrD/PCD hold; resumes at 16 after release.
- Taken branch: PCSrcE=01, PCTargetE=32'h40, FlushD=1 for one cycle -> next edge PCF=32'h40, ValidD=0, InstrD=NOP; following edge InstrD=imem[32'h40], ValidD=1.
- JALR with odd target: PCSrcE=10, ALUResultE=32'h107 -> PCF=32'h106, MisalignF=1 and sticky until rst.
- Simultaneous: StallF=StallD=1 with PCSrcE=01, FlushD=1 -> PC redirects, D flushed (flush and redirect win); PC wrap: PCF=32'hFFFFFFFC -> next PCF=0.
